serial_word_feeder: RTL
=======================

Name: serial_word_feeder

Overview:
Parallel-to-serial front end that sits directly upstream of the team's bidirectional shift register. It accepts parallel words over a valid/ready handshake and buffers one word in a skid slot. It then drives one bit per clock into the shifter's serial input, together with a matching direction/mode bit and a shift-enable strobe. An optional idle gap separates consecutive frames.

Parameters:
WIDTH, 8, word width in bits (>=2)
GAP_CYCLES, 1, idle cycles inserted after each frame (0 = back-to-back frames)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
data_in  input  WIDTH  parallel word to transmit
msb_first  input  1  direction for this word: 1 = MSB first, 0 = LSB first
data_valid  input  1  upstream word present
data_ready  output  1  feeder can accept a word this cycle
ser_out  output  1  serial bit to shifter serial input
ser_mode  output  1  direction of the frame in flight, wired to shifter mode
ser_en  output  1  high on every cycle ser_out carries a valid bit
busy  output  1  frame in SHIFT or GAP, or skid slot occupied
frame_done  output  1  one-cycle pulse on the cycle the last bit of a frame is driven

Behaviour:
- Reset (async, immediate): all of the following go to 0 while rst=1 and on release:
  - ser_out, ser_mode, ser_en, busy, frame_done
  - state=IDLE, bit counter, shift register, skid slot empty
- data_ready is 0 during reset.
- data_ready=1 whenever the skid slot is empty, in any state. It is a registered-state function, not combinationally dependent on data_valid.
- Transfer occurs on a rising edge with data_valid=1 and data_ready=1. data_in and msb_first are captured together; msb_first changes after capture do not affect the frame.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - If a transfer occurs, go to SHIFT and load the word into the shift register.
  - The first bit appears on ser_out the cycle after the accepting edge, so latency is 1 cycle.
  - If the skid slot is full, load from the slot instead.
- SHIFT:
  - ser_en=1 for exactly WIDTH consecutive cycles.
  - msb_first=1: bits go out from WIDTH-1 down to 0. msb_first=0: bits go out from 0 up to WIDTH-1.
  - ser_mode holds the captured msb_first for the whole frame.
  - Bit counter runs 0..WIDTH-1.
  - frame_done=1 on the cycle the counter is at WIDTH-1.
- Exit from SHIFT after the last bit:
  - If GAP_CYCLES>0, go to GAP.
  - Else if the skid slot is full or a transfer occurs on that edge, go directly to SHIFT with the next word, with no bubble.
  - Else go to IDLE.
- Words accepted during SHIFT/GAP go to the skid slot. data_ready drops the cycle after the slot fills.
- GAP:
  - ser_en=0, ser_out=0, ser_mode holds its last value.
  - Lasts exactly GAP_CYCLES cycles.
  - Then go to SHIFT if a word is pending (slot or simultaneous transfer), else IDLE.
- Outside SHIFT: ser_en=0 and ser_out=0.
- busy = (state != IDLE) or slot full.
- Simultaneous slot drain and new transfer on the same edge:
  - The slot word moves to the shift register and the new word enters the slot.
  - No word is lost or duplicated; order is strictly FIFO.
- Reset asserted mid-frame: the frame is abandoned, no frame_done is emitted, and the slot contents are discarded.
- Counter width is clog2(WIDTH). The counter never exceeds WIDTH-1.

Test Plan:
- Reset: hold rst=1 for 2 cycles with data_valid=1 -> all outputs 0, no word accepted. After release, data_ready=1.
- MSB-first, WIDTH=8, GAP=1: send 0xB4, msb_first=1 -> on the 8 cycles after acceptance:
  - ser_out=1,0,1,1,0,1,0,0
  - ser_en=1, ser_mode=1
  - frame_done on the 8th bit
  - then 1 gap cycle with ser_en=0, then IDLE
- LSB-first: send 0xB4, msb_first=0 -> ser_out=0,0,1,0,1,1,0,1, with ser_mode=0 throughout.
- Back-to-back, GAP=0: send 0xB4 (msb) then 0x0F (lsb) while the first is shifting ->
  - 16 contiguous ser_en cycles: 1,0,1,1,0,1,0,0 followed by 1,1,1,1,0,0,0,0
  - ser_mode switches 1->0 exactly at bit 9
  - data_ready low while the slot is full
- Backpressure: present three words during one frame -> the second fills the slot, the third is held (data_ready=0) until the slot drains. All three are serialized in order.
- Mid-frame reset: assert rst after bit 3 of 0xB4 with a word in the slot -> outputs 0 immediately, no frame_done. After release, a new word 0x81 (msb) shifts out 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/serial_word_feeder_if.sv
// Handshake and serial-output bundle for serial_word_feeder.
// The master side is the upstream word source. The slave side is the feeder.
interface serial_word_feeder_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] data_in;
   logic             msb_first;
   logic             data_valid;
   logic             data_ready;
   logic             ser_out;
   logic             ser_mode;
   logic             ser_en;
   logic             busy;
   logic             frame_done;

   modport master (
      output data_in, msb_first, data_valid,
      input  data_ready, ser_out, ser_mode, ser_en, busy, frame_done
   );

   modport slave (
      input  data_in, msb_first, data_valid,
      output data_ready, ser_out, ser_mode, ser_en, busy, frame_done
   );
endinterface

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: accepts words over valid/ready with a one-word skid slot,
// and streams them bit-serially with a direction bit, an enable strobe and an optional gap.
module serial_word_feeder #(
   parameter int WIDTH      = 8,
   parameter int GAP_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   serial_word_feeder_if.slave  bus
);

   localparam int CW = $clog2(WIDTH);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] slot_q, slot_d;
   logic             slot_mode_q, slot_mode_d;
   logic             slot_full_q, slot_full_d;
   logic             ser_mode_q, ser_mode_d;
   logic             ser_out_q, ser_out_d;
   logic             ser_en_q, ser_en_d;
   logic             frame_done_q, frame_done_d;
   logic             busy_q, busy_d;
   logic             data_ready_q, data_ready_d;

   logic             xfer;
   logic             can_load;
   logic             take;
   logic [WIDTH-1:0] next_word;
   logic             next_mode;

   always_comb begin
      xfer      = bus.data_valid & data_ready_q;
      next_word = slot_full_q ? slot_q : bus.data_in;
      next_mode = slot_full_q ? slot_mode_q : bus.msb_first;

      state_d    = state_q;
      cnt_d      = cnt_q;
      gap_d      = gap_q;
      shreg_d    = shreg_q;
      ser_mode_d = ser_mode_q;
      can_load   = 1'b0;

      case (state_q)
         IDLE: begin
            can_load = 1'b1;
         end
         SHIFT: begin
            if (cnt_q == CNT_LAST) begin
               if (GAP_CYCLES > 0) begin
                  state_d = GAP;
                  gap_d   = '0;
               end else begin
                  state_d  = IDLE;
                  can_load = 1'b1;
               end
            end else begin
               cnt_d   = cnt_q + CW'(1);
               shreg_d = ser_mode_q ? (shreg_q << 1) : (shreg_q >> 1);
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d  = IDLE;
               can_load = 1'b1;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      take = can_load & (slot_full_q | xfer);
      if (take) begin
         state_d    = SHIFT;
         cnt_d      = '0;
         shreg_d    = next_word;
         ser_mode_d = next_mode;
      end

      // The slot drains first; an incoming word lands in the slot unless it was loaded straight into the shifter.
      slot_d      = slot_q;
      slot_mode_d = slot_mode_q;
      slot_full_d = slot_full_q;
      if (take && slot_full_q) begin
         slot_full_d = 1'b0;
      end
      if (xfer && !(take && !slot_full_q)) begin
         slot_d      = bus.data_in;
         slot_mode_d = bus.msb_first;
         slot_full_d = 1'b1;
      end

      ser_en_d     = (state_d == SHIFT);
      ser_out_d    = ser_en_d & (ser_mode_d ? shreg_d[WIDTH-1] : shreg_d[0]);
      frame_done_d = ser_en_d & (cnt_d == CNT_LAST);
      busy_d       = (state_d != IDLE) | slot_full_d;
      data_ready_d = ~slot_full_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         gap_q        <= '0;
         shreg_q      <= '0;
         slot_q       <= '0;
         slot_mode_q  <= 1'b0;
         slot_full_q  <= 1'b0;
         ser_mode_q   <= 1'b0;
         ser_out_q    <= 1'b0;
         ser_en_q     <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
         data_ready_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         gap_q        <= gap_d;
         shreg_q      <= shreg_d;
         slot_q       <= slot_d;
         slot_mode_q  <= slot_mode_d;
         slot_full_q  <= slot_full_d;
         ser_mode_q   <= ser_mode_d;
         ser_out_q    <= ser_out_d;
         ser_en_q     <= ser_en_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
         data_ready_q <= data_ready_d;
      end
   end

   assign bus.data_ready = data_ready_q;
   assign bus.ser_out    = ser_out_q;
   assign bus.ser_mode   = ser_mode_q;
   assign bus.ser_en     = ser_en_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = frame_done_q;

endmodule
